ucsbece154b_fetch_unit: RTL
===========================

// Module: ucsbece154b_fetch_unit
// PURPOSE
// Fetch stage and IF/ID pipeline register for the pipelined RISC-V core. It acts on the
// hazard/redirect signals from the controller (StallF, StallD, FlushD, PCSrcE) and issues
// requests to a variable-latency instruction memory over a req/ack handshake. Decode receives
// InstrD/PCD/PCPlus4D plus a valid bit; FetchBusy_o reports an empty fetch slot.
// PARAMETERS
// RESET_PC  32'h0001_0000  PCF value loaded on reset; first address fetched
// NOP_INSTR 32'h0000_0013  value driven on InstrD_o when the slot is flushed or a bubble (addi x0,x0,0)
// PORTS
// clk           in   1   clock, all state updates on posedge
// reset         in   1   synchronous, active-high
// StallF_i      in   1   hold PCF / do not consume the fetched instruction
// StallD_i      in   1   hold the IF/ID register
// FlushD_i      in   1   clear the IF/ID register to a bubble
// PCSrcE_i      in   1   redirect: taken branch or jump resolved in E
// PCTargetE_i   in   32  redirect target; bits [1:0] are ignored and forced to 0
// imem_req_o    out  1   instruction memory request
// imem_addr_o   out  32  request address; stable while imem_req_o=1 and ack not yet seen
// imem_ack_i    in   1   response valid; one ack per request, may arrive in the request cycle
// imem_rdata_i  in   32  instruction word, valid with imem_ack_i
// InstrD_o      out  32  instruction in D
// PCD_o         out  32  PC of InstrD_o
// PCPlus4D_o    out  32  PCD_o + 4 (mod 2^32)
// ValidD_o      out  1   InstrD_o is a real instruction (0 = bubble)
// FetchBusy_o   out  1   no instruction available to hand to D this cycle
// BEHAVIOUR
// Reset values: PCF=RESET_PC, state=REQ, imem_req_o=0 during the reset cycle, imem_addr_o=RESET_PC,
//   InstrD_o=NOP_INSTR, PCD_o=0, PCPlus4D_o=0, ValidD_o=0, buffer empty.
// Registers: PCF; ReqAddr (drives imem_addr_o); BufInstr/BufPC (HOLD buffer); state in {REQ, HOLD, DROP}.
// REQ: imem_req_o=1, imem_addr_o=ReqAddr=PCF.
//   - ack & PCSrcE_i: response discarded; PCF<=ReqAddr<=target; stay REQ.
//   - ack & !PCSrcE_i & StallF_i: BufInstr<=rdata, BufPC<=PCF; go HOLD.
//   - ack & !PCSrcE_i & !StallF_i: instruction delivered to D; PCF<=ReqAddr<=PCF+4; stay REQ.
//   - no ack & PCSrcE_i: PCF<=target; ReqAddr held; go DROP.
//   - no ack & !PCSrcE_i: stay REQ; PCF and ReqAddr held.
// DROP: imem_req_o=1 with the old ReqAddr until ack; PCSrcE_i here updates PCF to the newest target;
//   on ack the response is discarded, ReqAddr<=PCF (or the new target if PCSrcE_i this cycle); go REQ.
// HOLD: imem_req_o=0. PCSrcE_i: drop the buffer, PCF<=ReqAddr<=target, go REQ. !StallF_i: deliver
//   the buffer to D, PCF<=ReqAddr<=BufPC+4, go REQ. Else stay.
// FetchBusy_o=1 in DROP, or in REQ without ack; 0 otherwise. Combinational.
// IF/ID register update priority per cycle: reset > FlushD_i (InstrD=NOP_INSTR, ValidD=0,
//   PCD/PCPlus4D held) > StallD_i (all held) > delivery (load instr, PC, PC+4, ValidD=1) >
//   otherwise bubble (NOP_INSTR, ValidD=0).
// Delivery requires !StallF_i. The environment keeps StallD_i=StallF_i; StallD_i=1 with StallF_i=0 is illegal.
// Fetch-to-D latency is 1 cycle after the ack, or 1 cycle after StallF_i drops in HOLD.
// Sequential fetch is back-to-back: a same-cycle ack gives one instruction per cycle.
// A discarded response never reaches D and never changes PCF except as stated above.
// PC arithmetic is 32-bit and wraps: 32'hFFFF_FFFC+4 = 0.
// Reset mid-request: the in-flight request is abandoned. imem shares reset and drops pending acks.
// TESTING
// Zero-wait imem (ack in the request cycle), no stalls: from reset, PCD_o steps 0x10000, 0x10004, ... one per cycle, ValidD=1.
// 3-cycle imem latency: FetchBusy_o=1 for 2 cycles per fetch; ValidD_o pulses 1 cycle after each ack; bubbles are NOP_INSTR.
// StallF_i=StallD_i=1 for 3 cycles when the ack arrives: state HOLD, D held, no new req; release -> buffered instr in D, next req to PC+4.
// PCSrcE_i=1, target 0x10101, with a request pending (no ack): DROP; old ack discarded; next req addr 0x10100; ValidD=0 for the dropped slot.
// PCSrcE_i and FlushD_i in the same cycle as an ack: response discarded, D shows a bubble, next imem_addr_o equals the target.
// Reset asserted in DROP/HOLD: next cycle imem_addr_o=RESET_PC, ValidD_o=0, InstrD_o=NOP_INSTR.

Source files
------------

// File: rtl/ucsbece154b_fetch_unit.sv
// ---------------------------------------------------------------------------
// ucsbece154b_fetch_unit
// Fetch stage plus IF/ID pipeline register for the pipelined RISC-V core.
// It issues requests to a variable-latency instruction memory over a req/ack
// handshake. It also handles stalls, flushes and redirects from the hazard
// unit.
//
// Ports
//   clk, reset      : clock (posedge), synchronous active-high reset
//   StallF_i        : hold PCF, do not consume a fetched instruction
//   StallD_i        : hold the IF/ID register
//   FlushD_i        : turn the IF/ID register into a bubble
//   PCSrcE_i        : redirect from E (taken branch / jump)
//   PCTargetE_i     : redirect target, low two bits forced to zero
//   imem_req_o      : instruction memory request
//   imem_addr_o     : request address, stable until the ack
//   imem_ack_i      : response valid (may arrive in the request cycle)
//   imem_rdata_i    : instruction word, valid with the ack
//   InstrD_o        : instruction in D
//   PCD_o           : PC of InstrD_o
//   PCPlus4D_o      : PCD_o + 4
//   ValidD_o        : InstrD_o is a real instruction
//   FetchBusy_o     : no instruction available to hand to D this cycle
// ---------------------------------------------------------------------------
module ucsbece154b_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0001_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF_i,
  input  logic        StallD_i,
  input  logic        FlushD_i,
  input  logic        PCSrcE_i,
  input  logic [31:0] PCTargetE_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] InstrD_o,
  output logic [31:0] PCD_o,
  output logic [31:0] PCPlus4D_o,
  output logic        ValidD_o,
  output logic        FetchBusy_o
);

  // REQ : request outstanding for PCF
  // HOLD: response captured in the buffer while F is stalled
  // DROP: an old request is still outstanding after a redirect; its
  //       response must be swallowed before the new target is fetched
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_pcF;
  logic [31:0] r_reqAddr;
  logic [31:0] r_bufInstr;
  logic [31:0] r_bufPC;
  logic [31:0] r_instrD;
  logic [31:0] r_pcD;
  logic [31:0] r_pcPlus4D;
  logic        r_validD;

  logic [31:0] w_target;
  logic [31:0] w_pcFNext;
  logic [31:0] w_reqAddrNext;
  logic [31:0] w_bufInstrNext;
  logic [31:0] w_bufPCNext;
  logic        w_deliver;
  logic [31:0] w_deliverInstr;
  logic [31:0] w_deliverPC;
  logic [31:0] w_deliverPCPlus4;

  // Targets are word aligned; masking keeps every input bit in use.
  assign w_target         = PCTargetE_i & 32'hFFFF_FFFC;
  assign w_deliverPCPlus4 = w_deliverPC + 32'd4;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_stateNext;
  end

  // Next-state and fetch-side datapath decisions
  always_comb begin
    w_stateNext    = r_state;
    w_pcFNext      = r_pcF;
    w_reqAddrNext  = r_reqAddr;
    w_bufInstrNext = r_bufInstr;
    w_bufPCNext    = r_bufPC;
    w_deliver      = 1'b0;
    w_deliverInstr = imem_rdata_i;
    w_deliverPC    = r_pcF;
    case (r_state)
      S_REQ: begin
        if (imem_ack_i) begin
          if (PCSrcE_i) begin
            // Response belongs to the wrong path: discard it.
            w_pcFNext     = w_target;
            w_reqAddrNext = w_target;
          end else if (StallF_i) begin
            w_bufInstrNext = imem_rdata_i;
            w_bufPCNext    = r_pcF;
            w_stateNext    = S_HOLD;
          end else begin
            w_deliver     = 1'b1;
            w_pcFNext     = r_pcF + 32'd4;
            w_reqAddrNext = r_pcF + 32'd4;
          end
        end else if (PCSrcE_i) begin
          // Request address must stay stable until its ack arrives.
          w_pcFNext   = w_target;
          w_stateNext = S_DROP;
        end
      end
      S_DROP: begin
        if (PCSrcE_i) w_pcFNext = w_target;
        if (imem_ack_i) begin
          w_reqAddrNext = PCSrcE_i ? w_target : r_pcF;
          w_stateNext   = S_REQ;
        end
      end
      S_HOLD: begin
        w_deliverInstr = r_bufInstr;
        w_deliverPC    = r_bufPC;
        if (PCSrcE_i) begin
          w_pcFNext     = w_target;
          w_reqAddrNext = w_target;
          w_stateNext   = S_REQ;
        end else if (!StallF_i) begin
          w_deliver     = 1'b1;
          w_pcFNext     = r_bufPC + 32'd4;
          w_reqAddrNext = r_bufPC + 32'd4;
          w_stateNext   = S_REQ;
        end
      end
      default: w_stateNext = S_REQ;
    endcase
  end

  // Handshake and status outputs
  always_comb begin
    imem_req_o  = 1'b0;
    FetchBusy_o = 1'b0;
    case (r_state)
      S_REQ: begin
        imem_req_o  = !reset;
        FetchBusy_o = !imem_ack_i;
      end
      S_DROP: begin
        imem_req_o  = !reset;
        FetchBusy_o = 1'b1;
      end
      default: begin
        imem_req_o  = 1'b0;
        FetchBusy_o = 1'b0;
      end
    endcase
  end

  assign imem_addr_o = r_reqAddr;

  // Fetch-side registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcF      <= RESET_PC;
      r_reqAddr  <= RESET_PC;
      r_bufInstr <= NOP_INSTR;
      r_bufPC    <= 32'd0;
    end else begin
      r_pcF      <= w_pcFNext;
      r_reqAddr  <= w_reqAddrNext;
      r_bufInstr <= w_bufInstrNext;
      r_bufPC    <= w_bufPCNext;
    end
  end

  // IF/ID register: flush beats stall beats delivery; otherwise a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instrD   <= NOP_INSTR;
      r_pcD      <= 32'd0;
      r_pcPlus4D <= 32'd0;
      r_validD   <= 1'b0;
    end else if (FlushD_i) begin
      r_instrD <= NOP_INSTR;
      r_validD <= 1'b0;
    end else if (StallD_i) begin
      r_validD <= r_validD;
    end else if (w_deliver) begin
      r_instrD   <= w_deliverInstr;
      r_pcD      <= w_deliverPC;
      r_pcPlus4D <= w_deliverPCPlus4;
      r_validD   <= 1'b1;
    end else begin
      r_instrD <= NOP_INSTR;
      r_validD <= 1'b0;
    end
  end

  assign InstrD_o   = r_instrD;
  assign PCD_o      = r_pcD;
  assign PCPlus4D_o = r_pcPlus4D;
  assign ValidD_o   = r_validD;

endmodule
